inst_immediate_stage: RTL and testbench
=======================================

# inst_immediate_stage

Registered immediate-decode stage between fetch and execute in the RV32/RV64 core. It accepts one instruction word and sideband tag per cycle over a valid/ready handshake and classifies its immediate format from the opcode. It produces the sign-extended immediate at XLEN width and buffers results in a 2-entry skid buffer, so execute-side stalls never combinationally reach fetch.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 32: width of the opaque sideband (PC or ID), passed through unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous pipeline flush; empties the buffer.
- in_valid  in  1  inst/tag are valid.
- in_ready  out  1  stage can accept; equals (count != 2), driven from state only.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  head entry is valid; equals (count != 0).
- out_ready  in  1  consumer accepts the head entry.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR (zimm), 7 unused.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  sideband of the head entry.

## Operation
- Format select by inst[6:0]:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111.
  - S: STORE 0100011.
  - B: BRANCH 1100011.
  - U: LUI 0110111, AUIPC 0010111.
  - J: JAL 1101111.
  - NONE: OP 0110011.
  - SYSTEM 1110011: CSR when inst[14]=1, otherwise I.
- XLEN=64 adds OP-IMM-32 0011011 → I and OP-32 0111011 → NONE. With XLEN=32 these two opcodes are illegal.
- Immediates, with sign bit inst[31] replicated up to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}, sign-extended for XLEN=64.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - CSR: zero-extended inst[19:15].
- NONE format gives out_imm = 0.
- Illegal: any other opcode, or inst[1:0] != 2'b11. Illegal entries give out_illegal=1, fmt NONE, imm 0, and the tag is still passed through.
- Decode is combinational on the input and is stored into the buffer on push. Outputs come from the head entry only.
- Buffer: 2 entries, strict FIFO order, count ∈ {0,1,2}.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - count' = count + push − pop.
- Simultaneous push and pop:
  - At count=1: the head is replaced by the new entry and count stays 1.
  - At count=2: push cannot occur; count becomes 1 and the second entry becomes head.
- Flush has priority over push and pop. The next cycle has count=0, and any input offered in the flush cycle is dropped.
- When out_valid=0, the out_imm/out_fmt/out_illegal/out_tag values are don't-care for consumers. The implementation must hold them at their last value or 0; X is not allowed.

## Timing
- Latency: a push at edge N gives out_valid=1 with that entry's data after edge N, i.e. 1 cycle.
- Throughput: 1 per cycle when out_ready is held high.
- Output timing:
  - in_ready and out_valid are pure functions of registered count, with no comb path from in_valid or out_ready.
  - Data outputs are registered.
- While rst_n=0:
  - count=0, out_valid=0, in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous).
- A consumer stall of any length is absorbed without loss: two entries are held, then in_ready=0 until a pop.

## Test plan
- XLEN=32, single pushes, out_ready=1:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt I.
  - 0xFE112E23 → 0xFFFFFFFC, fmt S.
  - 0xFE000CE3 → 0xFFFFFFF8, fmt B.
  - Each result appears 1 cycle after its push.
- U, J and CSR formats:
  - 0x123450B7 → 0x12345000, fmt U.
  - 0x001000EF → 0x00000800, fmt J.
  - 0x300FD073 → 0x0000001F, fmt CSR.
  - 0x00000033 → imm 0, fmt NONE, illegal 0.
- XLEN=64:
  - 0x800000B7 → 0xFFFFFFFF80000000.
  - 0xFFF0009B → 0xFFFFFFFFFFFFFFFF, fmt I.
  - The same 0x0000009B at XLEN=32 → illegal=1.
- Backpressure:
  - Hold out_ready=0 and push tags 1,2,3 back-to-back. Tag 3 is held off because in_ready=0 after two pushes.
  - Release out_ready: tags emerge in order 1,2,3 with no loss or duplication.
  - Exercise simultaneous push and pop at count=1 and at count=2 and check count after each.
- Flush with count=2 while in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed-cycle input never appears.
- Assert rst_n=0 asynchronously with count=2 → all outputs reach their reset values before the next clock edge. After release, one push of 0x00000003 → illegal 0, fmt I, imm 0.

Source files
------------

// File: rtl/inst_immediate_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_immediate_stage: immediate-format decode into a 2-entry skid buffer  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module inst_immediate_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_fmt,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_CSR  = 3'd6;
  localparam bit         IS_RV64  = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     head;
  entry_t     second;
  entry_t     dec;
  logic [1:0] count;
  logic [2:0] dec_fmt;
  logic       dec_ill;
  logic [31:0] imm32;
  logic       push;
  logic       pop;

  // Every legal opcode ends in 2'b11, so the default arm also covers inst[1:0] != 2'b11.
  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      7'b0110011: dec_fmt = FMT_NONE;
      7'b1110011: dec_fmt = in_inst[14] ? FMT_CSR : FMT_I;
      7'b0011011: begin
        if (IS_RV64) dec_fmt = FMT_I;
        else         dec_ill = 1'b1;
      end
      7'b0111011: begin
        if (!IS_RV64) dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                        in_inst[11:8], 1'b0};
      FMT_U:   imm32 = {in_inst[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                        in_inst[30:21], 1'b0};
      FMT_CSR: imm32 = {27'b0, in_inst[19:15]};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = dec_fmt;
    dec.illegal = dec_ill;
    dec.tag     = in_tag;
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Push and pop together is only possible at count==1, where the new entry replaces the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      head   <= '0;
      second <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head   <= dec;
          else               second <= dec;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= second;
          count <= count - 2'd1;
        end
        2'b11:   head <= dec;
        default: ;
      endcase
    end
  end

  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;
  assign out_tag     = head.tag;

endmodule
`default_nettype wire

// File: tb/tb_inst_immediate_stage.sv
`default_nettype none
// Testbench for inst_immediate_stage: XLEN=32 and XLEN=64 instances share stimulus,
// each checked by a queue scoreboard fed from an arithmetic reference model.
module tb_inst_immediate_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_tag;

  logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  inst_immediate_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32));

  inst_immediate_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: immediate value computed as a signed integer from the instruction fields.
  function automatic exp_t model(input logic [31:0] inst, input bit rv64, input logic [31:0] tag);
    exp_t   r;
    longint v;
    int     f;
    bit     ill;
    f = 0; ill = 0; v = 0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: f = 1;
      7'h23: f = 2;
      7'h63: f = 3;
      7'h37, 7'h17: f = 4;
      7'h6F: f = 5;
      7'h33: f = 0;
      7'h73: f = inst[14] ? 6 : 1;
      7'h1B: if (rv64) f = 1; else ill = 1;
      7'h3B: if (!rv64) ill = 1;
      default: ill = 1;
    endcase
    if (ill) f = 0;
    case (f)
      1: begin v = longint'(inst[31:20]); if (inst[31]) v -= 4096; end
      2: begin v = longint'({inst[31:25], inst[11:7]}); if (inst[31]) v -= 4096; end
      3: begin
        v = longint'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
        if (inst[31]) v -= 8192;
      end
      4: begin v = longint'(inst[31:12]) * 4096; if (inst[31]) v -= (longint'(1) << 32); end
      5: begin
        v = longint'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
        if (inst[31]) v -= (longint'(1) << 21);
      end
      6: v = longint'(inst[19:15]);
      default: v = 0;
    endcase
    r.imm = rv64 ? 64'(v) : {32'b0, 32'(v)};
    r.fmt = 3'(f);
    r.ill = ill;
    r.tag = tag;
    return r;
  endfunction

  // Scoreboard fill: record every accepted input.
  always @(negedge clk) begin
    if (rst_n && in_valid && rdy32 && !flush) begin
      q32.push_back(model(in_inst, 1'b0, in_tag));
      q64.push_back(model(in_inst, 1'b1, in_tag));
    end
  end

  // Monitors: compare head against the oldest expected entry whenever out_valid is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov32) begin
        if (q32.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL x32_unexpected_output: got tag %h expected no output", tag32);
        end else begin
          chk("x32_imm", {32'b0, imm32}, q32[0].imm);
          chk("x32_fmt", 64'(fmt32), 64'(q32[0].fmt));
          chk("x32_ill", 64'(ill32), 64'(q32[0].ill));
          chk("x32_tag", 64'(tag32), 64'(q32[0].tag));
        end
      end
      if (flush) q32.delete();
      else if (ov32 && out_ready && q32.size() > 0) void'(q32.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov64) begin
        if (q64.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL x64_unexpected_output: got tag %h expected no output", tag64);
        end else begin
          chk("x64_imm", imm64, q64[0].imm);
          chk("x64_fmt", 64'(fmt64), 64'(q64[0].fmt));
          chk("x64_ill", 64'(ill64), 64'(q64[0].ill));
          chk("x64_tag", 64'(tag64), 64'(q64[0].tag));
        end
      end
      if (flush) q64.delete();
      else if (ov64 && out_ready && q64.size() > 0) void'(q64.pop_front());
    end
  end

  logic [31:0] d_inst  [10] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7,
                                32'h001000EF, 32'h300FD073, 32'h00000033, 32'h800000B7,
                                32'hFFF0009B, 32'h0000009B};
  logic [31:0] d_imm32 [10] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                32'h00000800, 32'h0000001F, 32'h0, 32'h80000000, 32'h0, 32'h0};
  logic [2:0]  d_fmt32 [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd4, 3'd0, 3'd0};
  logic        d_ill32 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic [63:0] d_imm64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                                64'h12345000, 64'h800, 64'h1F, 64'h0, 64'hFFFFFFFF80000000,
                                64'hFFFFFFFFFFFFFFFF, 64'h0};
  logic [2:0]  d_fmt64 [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd4, 3'd1, 3'd1};
  logic [6:0]  ops     [13] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17,
                                7'h6F, 7'h33, 7'h73, 7'h1B, 7'h3B};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_tag = '0;

    #12;
    chk("rst_in_ready", 64'(rdy32), 64'd1);
    chk("rst_out_valid", 64'({ov32, ov64}), 64'd0);
    chk("rst_imm", {32'b0, imm32} | imm64, 64'd0);
    chk("rst_fmt_ill_tag", {fmt32, ill32, tag32}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Directed decode table, one push at a time, checked one cycle after the push edge.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_inst = d_inst[i]; in_tag = i;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("dir%0d_latency_valid", i), 64'({ov32, ov64}), 64'd3);
      chk($sformatf("dir%0d_imm32", i), 64'(imm32), 64'(d_imm32[i]));
      chk($sformatf("dir%0d_fmt_ill32", i), 64'({fmt32, ill32}), 64'({d_fmt32[i], d_ill32[i]}));
      chk($sformatf("dir%0d_imm64", i), imm64, d_imm64[i]);
      chk($sformatf("dir%0d_fmt_ill64", i), 64'({fmt64, ill64}), 64'({d_fmt64[i], 1'b0}));
    end

    // Backpressure: two entries buffered, third held off, then drained in order.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 101;
    @(posedge clk); #1; in_tag = 102;
    @(posedge clk); #1; in_tag = 103;
    @(negedge clk);
    chk("bp_full_ready", 64'({rdy32, rdy64}), 64'd0);
    chk("bp_full_valid", 64'({ov32, ov64}), 64'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_stall_ready", 64'(rdy32), 64'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("count2_pop_count1", 64'({rdy32, ov32}), 64'd3);
    chk("count2_pop_head", 64'(tag32), 64'd102);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("count1_pushpop_count1", 64'({rdy32, ov32}), 64'd3);
    chk("count1_pushpop_head", 64'(tag32), 64'd103);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drained", 64'(ov32), 64'd0);

    // Flush at count=2 with a live input.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00000013; in_tag = 201;
    @(posedge clk); #1; in_tag = 202;
    @(posedge clk); #1; flush = 1'b1; in_tag = 203;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'({ov32, ov64}), 64'd0);
    chk("flush_in_ready", 64'({rdy32, rdy64}), 64'd3);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    // Asynchronous reset with two entries held.
    #1; out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFE112E23; in_tag = 301;
    @(posedge clk); #1; in_tag = 302;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_full", 64'(rdy32), 64'd0);
    @(posedge clk); #3; rst_n = 1'b0;
    #1;
    chk("async_rst_valid_ready", 64'({ov32, rdy32, ov64, rdy64}), 64'b0101);
    chk("async_rst_imm", {32'b0, imm32} | imm64, 64'd0);
    chk("async_rst_fields", {fmt32, ill32, tag32}, 64'd0);
    chk("async_rst_fields64", {fmt64, ill64, tag64}, 64'd0);
    q32.delete(); q64.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00000003; in_tag = 400;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 64'(ov32), 64'd1);
    chk("post_rst_decode", {32'b0, imm32, fmt32, ill32}, 64'h2);

    // Randomized traffic with random backpressure and occasional flush.
    for (int k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      flush     = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_inst   = $urandom;
      if ($urandom_range(0, 9) != 0) in_inst[6:0] = ops[$urandom_range(0, 12)];
      in_tag    = 32'd1000 + 32'(k);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_queue32_empty", 64'(q32.size()), 64'd0);
    chk("drain_queue64_empty", 64'(q64.size()), 64'd0);
    chk("drain_out_valid", 64'({ov32, ov64}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
